// File: rtl/imem_wb_loader_if.sv
// ---------------------------------------------------------------------------
// imem_wb_loader_if
// Wishbone slave bundle between the user-project Wishbone bus and the
// instruction-memory loader.
//   wbs_cyc_i / wbs_stb_i : cycle and strobe from the master
//   wbs_we_i              : 1 = write, 0 = read
//   wbs_sel_i [3:0]       : byte selects
//   wbs_adr_i [31:0]      : byte address
//   wbs_dat_i [31:0]      : write data
//   wbs_ack_o             : one-cycle acknowledge from the slave
//   wbs_dat_o [31:0]      : read data, zero whenever ack is low
// ---------------------------------------------------------------------------
interface imem_wb_loader_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/imem_wb_loader.sv
// ---------------------------------------------------------------------------
// imem_wb_loader
// Wishbone slave owning port 0 of the 32x512 instruction SRAM. The host loads
// and reads back programs through it, and controls a core-hold line that keeps
// the SLRV core in reset while the program is written.
//
// Ports:
//   wb_clk_i    system clock, rising edge
//   wb_rst_n    asynchronous active-low reset
//   wb          Wishbone slave bundle (imem_wb_loader_if.slave)
//   csb0, web0  SRAM port-0 chip select / write enable, active low
//   wmask0      SRAM byte write mask
//   addr0       SRAM word address
//   din0        SRAM write data
//   dout0       SRAM port-0 read data
//   core_hold   1 = SLRV core held in reset
//
// Window map (offset from BASE_ADDR):
//   0x0000-0x07FC SRAM words, 0x1000 CTRL (bit0 core_hold),
//   0x1004 STATUS ([9:0] written-word count, [16] busy, [17] write-reject),
//   anything else acked, reads 0, writes dropped.
// ---------------------------------------------------------------------------
module imem_wb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          ADDR_W    = 9,
    parameter int          READ_LAT  = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    imem_wb_loader_if.slave   wb,
    output logic              csb0,
    output logic              web0,
    output logic [3:0]        wmask0,
    output logic [ADDR_W-1:0] addr0,
    output logic [31:0]       din0,
    input  logic [31:0]       dout0,
    output logic              core_hold
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SWR   = 3'd1,
        ST_SRD   = 3'd2,
        ST_RWAIT = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    localparam logic [10:0] SRAM_LAST_WORD = 11'((1 << ADDR_W) - 1);
    localparam logic [10:0] CTRL_WORD      = 11'h400;
    localparam logic [10:0] STATUS_WORD    = 11'h401;
    localparam logic [2:0]  WAIT_INIT      = 3'(READ_LAT);

    // Count of SRAM words written; sticks at its maximum rather than wrapping.
    function automatic logic [9:0] sat_inc(input logic [9:0] cnt);
        sat_inc = (cnt == 10'h3FF) ? cnt : cnt + 10'd1;
    endfunction

    // STATUS read image; busy always reads 0 because reads are only acked from IDLE.
    function automatic logic [31:0] status_word(input logic [9:0] cnt, input logic err);
        status_word = {14'h0, err, 1'b0, 6'h0, cnt};
    endfunction

    state_t            state_r, state_nxt_s;
    logic              csb0_r, csb0_nxt_s;
    logic              web0_r, web0_nxt_s;
    logic [3:0]        wmask0_r, wmask0_nxt_s;
    logic [ADDR_W-1:0] addr0_r, addr0_nxt_s;
    logic [31:0]       din0_r, din0_nxt_s;
    logic              ack_r, ack_nxt_s;
    logic [31:0]       dat_r, dat_nxt_s;
    logic              hold_r, hold_nxt_s;
    logic [9:0]        count_r, count_nxt_s;
    logic              err_r, err_nxt_s;
    logic [2:0]        wait_r, wait_nxt_s;

    logic              hit_s;
    logic [10:0]       word_off_s;
    logic              sram_sel_s;
    logic              ctrl_sel_s;
    logic              status_sel_s;
    logic              adr_unused_s;

    assign hit_s        = wb.wbs_cyc_i & wb.wbs_stb_i &
                          (wb.wbs_adr_i[31:13] == BASE_ADDR[31:13]);
    assign word_off_s   = wb.wbs_adr_i[12:2];
    assign sram_sel_s   = (word_off_s <= SRAM_LAST_WORD);
    assign ctrl_sel_s   = (word_off_s == CTRL_WORD);
    assign status_sel_s = (word_off_s == STATUS_WORD);
    // Byte offset within a word carries no meaning for word-wide accesses.
    assign adr_unused_s = ^wb.wbs_adr_i[1:0];

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_nxt_s  = state_r;
        csb0_nxt_s   = 1'b1;
        web0_nxt_s   = 1'b1;
        wmask0_nxt_s = 4'h0;
        addr0_nxt_s  = addr0_r;
        din0_nxt_s   = din0_r;
        ack_nxt_s    = 1'b0;
        dat_nxt_s    = 32'h0;
        hold_nxt_s   = hold_r;
        count_nxt_s  = count_r;
        err_nxt_s    = err_r;
        wait_nxt_s   = wait_r;

        case (state_r)
            ST_IDLE: begin
                if (hit_s && !ack_r) begin
                    if (sram_sel_s) begin
                        if (wb.wbs_we_i) begin
                            if (hold_r) begin
                                state_nxt_s  = ST_SWR;
                                csb0_nxt_s   = 1'b0;
                                web0_nxt_s   = 1'b0;
                                wmask0_nxt_s = wb.wbs_sel_i;
                                addr0_nxt_s  = wb.wbs_adr_i[ADDR_W+1:2];
                                din0_nxt_s   = wb.wbs_dat_i;
                            end else begin
                                // Core is fetching from this SRAM: refuse and flag it.
                                state_nxt_s = ST_ACK;
                                ack_nxt_s   = 1'b1;
                                err_nxt_s   = 1'b1;
                            end
                        end else begin
                            state_nxt_s = ST_SRD;
                            csb0_nxt_s  = 1'b0;
                            addr0_nxt_s = wb.wbs_adr_i[ADDR_W+1:2];
                        end
                    end else begin
                        state_nxt_s = ST_ACK;
                        ack_nxt_s   = 1'b1;
                        if (ctrl_sel_s) begin
                            if (wb.wbs_we_i) begin
                                hold_nxt_s = wb.wbs_dat_i[0];
                            end else begin
                                dat_nxt_s = {31'h0, hold_r};
                            end
                        end else if (status_sel_s) begin
                            if (wb.wbs_we_i) begin
                                count_nxt_s = 10'h0;
                                err_nxt_s   = 1'b0;
                            end else begin
                                dat_nxt_s = status_word(count_r, err_r);
                            end
                        end else begin
                            dat_nxt_s = 32'h0;
                        end
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SWR: begin
                // The SRAM captured the write at the edge closing this state.
                state_nxt_s = ST_ACK;
                ack_nxt_s   = 1'b1;
                count_nxt_s = sat_inc(count_r);
            end
            ST_SRD: begin
                state_nxt_s = ST_RWAIT;
                wait_nxt_s  = WAIT_INIT;
            end
            ST_RWAIT: begin
                // A corrupted zero count is treated like 1 so the wait always ends.
                if (wait_r <= 3'd1) begin
                    state_nxt_s = ST_ACK;
                    ack_nxt_s   = 1'b1;
                    dat_nxt_s   = dout0;
                end else begin
                    wait_nxt_s = wait_r - 3'd1;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output storage.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_r  <= ST_IDLE;
            csb0_r   <= 1'b1;
            web0_r   <= 1'b1;
            wmask0_r <= 4'h0;
            addr0_r  <= '0;
            din0_r   <= 32'h0;
            ack_r    <= 1'b0;
            dat_r    <= 32'h0;
            hold_r   <= 1'b1;
            count_r  <= 10'h0;
            err_r    <= 1'b0;
            wait_r   <= 3'h0;
        end else begin
            state_r  <= state_nxt_s;
            csb0_r   <= csb0_nxt_s;
            web0_r   <= web0_nxt_s;
            wmask0_r <= wmask0_nxt_s;
            addr0_r  <= addr0_nxt_s;
            din0_r   <= din0_nxt_s;
            ack_r    <= ack_nxt_s;
            dat_r    <= dat_nxt_s;
            hold_r   <= hold_nxt_s;
            count_r  <= count_nxt_s;
            err_r    <= err_nxt_s;
            wait_r   <= wait_nxt_s;
        end
    end

    assign csb0         = csb0_r;
    assign web0         = web0_r;
    assign wmask0       = wmask0_r;
    assign addr0        = addr0_r;
    assign din0         = din0_r;
    assign core_hold    = hold_r;
    assign wb.wbs_ack_o = ack_r;
    assign wb.wbs_dat_o = dat_r;

endmodule

// File: tb/tb_imem_wb_loader.sv
module tb_imem_wb_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk;
    logic        rst_n;
    logic        csb0;
    logic        web0;
    logic [3:0]  wmask0;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0;
    logic        core_hold;

    imem_wb_loader_if bus ();

    imem_wb_loader #(
        .BASE_ADDR (BASE),
        .ADDR_W    (9),
        .READ_LAT  (2)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .wb        (bus),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
        .dout0     (dout0),
        .core_hold (core_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM port-0 model: captures on the rising edge while selected.
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    int          lat_v;
    logic [31:0] rdata_v;
    logic [31:0] after_v;
    logic        csb_seen;
    logic        c1_csb, c1_web;
    logic [3:0]  c1_mask;
    logic [8:0]  c1_addr;

    // One Wishbone access; call #1 after a rising edge. lat_v=0 means no ack in bound.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int bound);
        lat_v    = 0;
        rdata_v  = 32'h0;
        csb_seen = 1'b0;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        for (int n = 1; n <= bound; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                c1_csb  = csb0;
                c1_web  = web0;
                c1_mask = wmask0;
                c1_addr = addr0;
            end
            if (!csb0) csb_seen = 1'b1;
            if (bus.wbs_ack_o) begin
                lat_v   = n;
                rdata_v = bus.wbs_dat_o;
                break;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(posedge clk); #1;
        after_v = bus.wbs_dat_o;
    endtask

    logic ack_seen;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        dout0 = 32'h0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = 32'h0;
        bus.wbs_dat_i = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_csb0", {31'h0, csb0}, 32'h1);
        check_value("rst_web0", {31'h0, web0}, 32'h1);
        check_value("rst_sram_side", {19'h0, wmask0, addr0} | din0, 32'h0);
        check_value("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        check_value("rst_dat", bus.wbs_dat_o, 32'h0);
        check_value("rst_core_hold", {31'h0, core_hold}, 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // CTRL read after reset.
        wb_xfer(1'b0, BASE + 32'h1000, 32'h0, 4'hF, 10);
        check_value("ctrl_rd_lat", lat_v, 32'd1);
        check_value("ctrl_rd_dat", rdata_v, 32'h1);
        check_value("ctrl_rd_no_csb", {31'h0, csb_seen}, 32'h0);
        check_value("ctrl_rd_dat_after", after_v, 32'h0);

        // Full-word SRAM write.
        wb_xfer(1'b1, BASE + 32'h0008, 32'hDEADBEEF, 4'hF, 10);
        check_value("wr_c1_csb", {31'h0, c1_csb}, 32'h0);
        check_value("wr_c1_web", {31'h0, c1_web}, 32'h0);
        check_value("wr_c1_addr", {23'h0, c1_addr}, 32'd2);
        check_value("wr_c1_mask", {28'h0, c1_mask}, 32'hF);
        check_value("wr_lat", lat_v, 32'd2);
        check_value("wr_mem2", mem[2], 32'hDEADBEEF);
        wb_xfer(1'b0, BASE + 32'h1004, 32'h0, 4'hF, 10);
        check_value("status_cnt1", rdata_v, 32'h0000_0001);

        // SRAM read back.
        wb_xfer(1'b0, BASE + 32'h0008, 32'h0, 4'hF, 10);
        check_value("rd_lat", lat_v, 32'd4);
        check_value("rd_dat", rdata_v, 32'hDEADBEEF);
        check_value("rd_dat_after", after_v, 32'h0);

        // Partial write, low two bytes only.
        wb_xfer(1'b1, BASE + 32'h0008, 32'h12345678, 4'h3, 10);
        wb_xfer(1'b0, BASE + 32'h0008, 32'h0, 4'hF, 10);
        check_value("partial_rd", rdata_v, 32'hDEAD5678);

        // sel=0 write: no bytes change, count still advances.
        wb_xfer(1'b1, BASE + 32'h000C, 32'hFFFFFFFF, 4'h0, 10);
        check_value("sel0_lat", lat_v, 32'd2);
        check_value("sel0_csb", {31'h0, csb_seen}, 32'h1);
        check_value("sel0_mem3", mem[3], 32'h0);
        wb_xfer(1'b0, BASE + 32'h1004, 32'h0, 4'hF, 10);
        check_value("status_cnt3", rdata_v, 32'h0000_0003);

        // Release the core, then a write must be rejected.
        wb_xfer(1'b1, BASE + 32'h1000, 32'h0, 4'hF, 10);
        check_value("hold_cleared", {31'h0, core_hold}, 32'h0);
        wb_xfer(1'b1, BASE + 32'h0010, 32'hCAFEF00D, 4'hF, 10);
        check_value("rej_lat", lat_v, 32'd1);
        check_value("rej_no_csb", {31'h0, csb_seen}, 32'h0);
        check_value("rej_mem4", mem[4], 32'h0);
        wb_xfer(1'b0, BASE + 32'h1004, 32'h0, 4'hF, 10);
        check_value("status_err", rdata_v, 32'h0002_0003);
        wb_xfer(1'b0, BASE + 32'h0008, 32'h0, 4'hF, 10);
        check_value("rd_while_running", rdata_v, 32'hDEAD5678);
        wb_xfer(1'b1, BASE + 32'h1004, 32'h0, 4'hF, 10);
        wb_xfer(1'b0, BASE + 32'h1004, 32'h0, 4'hF, 10);
        check_value("status_cleared", rdata_v, 32'h0);

        // Unmapped offset inside the window, and an address outside it.
        wb_xfer(1'b0, BASE + 32'h1008, 32'h0, 4'hF, 10);
        check_value("unmapped_lat", lat_v, 32'd1);
        check_value("unmapped_dat", rdata_v, 32'h0);
        wb_xfer(1'b1, 32'h4000_0008, 32'h55555555, 4'hF, 6);
        check_value("nonhit_no_ack", lat_v, 32'd0);
        check_value("nonhit_no_csb", {31'h0, csb_seen}, 32'h0);

        // 1030 writes: count saturates, addresses wrap inside the SRAM region.
        wb_xfer(1'b1, BASE + 32'h1000, 32'h1, 4'hF, 10);
        check_value("hold_set", {31'h0, core_hold}, 32'h1);
        for (int i = 0; i < 1030; i++) begin
            wb_xfer(1'b1, BASE + ((i * 4) % 2048), 32'hA500_0000 + i, 4'hF, 10);
            if (lat_v != 2) check_value("bulk_wr_lat", lat_v, 32'd2);
        end
        wb_xfer(1'b0, BASE + 32'h1004, 32'h0, 4'hF, 10);
        check_value("status_sat", rdata_v, 32'h0000_03FF);
        wb_xfer(1'b0, BASE + 32'h07FC, 32'h0, 4'hF, 10);
        check_value("word511", rdata_v, 32'hA50003FF);
        wb_xfer(1'b0, BASE + 32'h0000, 32'h0, 4'hF, 10);
        check_value("word0", rdata_v, 32'hA5000400);
        wb_xfer(1'b0, BASE + 32'h0014, 32'h0, 4'hF, 10);
        check_value("word5", rdata_v, 32'hA5000405);

        // Reset during RWAIT with the core released.
        wb_xfer(1'b1, BASE + 32'h1000, 32'h0, 4'hF, 10);
        check_value("hold_cleared2", {31'h0, core_hold}, 32'h0);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = BASE + 32'h07FC;
        @(posedge clk); #1;
        check_value("rst_mid_srd_csb", {31'h0, csb0}, 32'h0);
        @(posedge clk); #1;
        check_value("rst_mid_rwait_csb", {31'h0, csb0}, 32'h1);
        rst_n = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        #1;
        check_value("rst_mid_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
        check_value("rst_mid_csb", {31'h0, csb0}, 32'h1);
        check_value("rst_mid_hold", {31'h0, core_hold}, 32'h1);
        ack_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) ack_seen = 1'b1;
        end
        check_value("rst_mid_no_late_ack", {31'h0, ack_seen}, 32'h0);
        wb_xfer(1'b0, BASE + 32'h0000, 32'h0, 4'hF, 10);
        check_value("post_rst_rd_lat", lat_v, 32'd4);
        check_value("post_rst_rd_dat", rdata_v, 32'hA5000400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
